// File: rtl/ipm_codec_if.sv
// Request/response bundle between a requester and the ipm_codec masking codec.
interface ipm_codec_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned WIDTH = N * 8;

  logic             req_valid_i;
  logic             req_ready_o;
  logic             mode_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] rnd_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] result_o;

  modport slave (
    input  req_valid_i, mode_i, data_i, rnd_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, result_o
  );

  modport master (
    output req_valid_i, mode_i, data_i, rnd_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, result_o
  );
endinterface

// File: rtl/ipm_codec.sv
// Iterative IPM encoder/decoder: converts a byte to/from N inner-product-masked
// shares using one GF(256) multiplier, one L[k]*B[k] term per cycle.
module ipm_codec #(
  parameter int unsigned N = 4
) (
  input logic        clk_i,
  input logic        reset_i,
  input logic        clear_i,
  ipm_codec_if.slave bus
);
  localparam int unsigned WIDTH = N * 8;
  localparam logic [1:0]  KLast = 2'(N - 1);

  if (N < 2 || N > 4) begin : g_bad_n
    $error("ipm_codec: N must be in 2..4");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic             mode_q;
  // Only shares 1..N-1 are needed after the handshake; share/secret 0 seeds acc.
  logic [WIDTH-9:0] data_q;
  logic [WIDTH-9:0] rnd_q;
  logic [7:0]       acc_q;
  logic [1:0]       k_q;
  logic [WIDTH-1:0] result_q;

  logic [7:0]       l_sel;
  logic [7:0]       b_sel;
  logic [WIDTH-9:0] b_vec;
  logic [7:0]       acc_next;

  // GF(256) multiply, polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplier operands selected by k only; no path from handshake inputs.
  always_comb begin
    l_sel = 8'h01;
    unique case (k_q)
      2'd1:    l_sel = 8'h1B;
      2'd2:    l_sel = 8'hFA;
      2'd3:    l_sel = 8'hBC;
      default: l_sel = 8'h01;
    endcase
    b_vec = mode_q ? data_q : rnd_q;
    b_sel = 8'h00;
    for (int i = 1; i < N; i++) begin
      if (k_q == 2'(i)) b_sel = b_vec[WIDTH-1-8*i -: 8];
    end
    acc_next = acc_q ^ gf_mul(l_sel, b_sel);
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; clear overrides every other event.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.req_valid_i) state_d = StCalc;
        StCalc:  if (k_q == KLast) state_d = StDone;
        StDone:  if (bus.rsp_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state and the registered result.
  always_comb begin
    bus.req_ready_o = (state_q == StIdle);
    bus.rsp_valid_o = (state_q == StDone);
    bus.result_o    = result_q;
  end

  // Datapath: operand latch, accumulation, result capture and scrubbing.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q   <= 1'b0;
      data_q   <= '0;
      rnd_q    <= '0;
      acc_q    <= 8'h00;
      k_q      <= 2'd1;
      result_q <= '0;
    end else if (clear_i) begin
      acc_q    <= 8'h00;
      k_q      <= 2'd1;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid_i) begin
            mode_q <= bus.mode_i;
            data_q <= bus.data_i[WIDTH-9:0];
            rnd_q  <= bus.rnd_i[WIDTH-9:0];
            // L[0] = 1, so share 0 enters the sum unmultiplied.
            acc_q  <= bus.mode_i ? bus.data_i[WIDTH-1 -: 8] : bus.data_i[7:0];
            k_q    <= 2'd1;
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          k_q   <= k_q + 2'd1;
          if (k_q == KLast) begin
            k_q      <= 2'd1;
            result_q <= mode_q ? {{(WIDTH-8){1'b0}}, acc_next} : {acc_next, rnd_q};
          end
        end
        StDone: begin
          // Scrub so no unmasked value lingers once consumed.
          if (bus.rsp_ready_i) begin
            acc_q    <= 8'h00;
            result_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ipm_codec.sv
// Directed self-checking bench for ipm_codec (N=4 main instance, N=2 side instance).
module tb_ipm_codec;
  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  ipm_codec_if #(.N(4)) bus4 ();
  ipm_codec_if #(.N(2)) bus2 ();

  ipm_codec #(.N(4)) u_dut4 (.clk_i(clk), .reset_i(rst), .clear_i(clr), .bus(bus4.slave));
  ipm_codec #(.N(2)) u_dut2 (.clk_i(clk), .reset_i(rst), .clear_i(clr), .bus(bus2.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the N=4 instance; returns 1ns after the handshake edge.
  task automatic send_req(input logic mode, input logic [31:0] data, input logic [31:0] rnd);
    int guard = 0;
    while (!bus4.req_ready_o && guard < 20) begin
      tick();
      guard++;
    end
    bus4.mode_i      = mode;
    bus4.data_i      = data;
    bus4.rnd_i       = rnd;
    bus4.req_valid_i = 1'b1;
    tick();
    bus4.req_valid_i = 1'b0;
  endtask

  // Cycles from the handshake edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!bus4.rsp_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept(input string tag);
    bus4.rsp_ready_i = 1'b1;
    tick();
    bus4.rsp_ready_i = 1'b0;
    check_val({tag, "_ready_after"}, 32'(bus4.req_ready_o), 32'd1);
    check_val({tag, "_scrub"}, bus4.result_o, 32'h0);
  endtask

  task automatic run_op(input string tag, input logic mode, input logic [31:0] data,
                        input logic [31:0] rnd, input logic [31:0] exp);
    int cyc;
    send_req(mode, data, rnd);
    check_val({tag, "_busy"}, 32'(bus4.req_ready_o), 32'd0);
    wait_rsp(cyc);
    check_val({tag, "_lat"}, 32'(cyc), 32'd3);
    check_val({tag, "_res"}, bus4.result_o, exp);
    accept(tag);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    clr = 1'b0;
    bus4.req_valid_i = 1'b0; bus4.mode_i = 1'b0; bus4.data_i = '0; bus4.rnd_i = '0;
    bus4.rsp_ready_i = 1'b0;
    bus2.req_valid_i = 1'b0; bus2.mode_i = 1'b0; bus2.data_i = '0; bus2.rnd_i = '0;
    bus2.rsp_ready_i = 1'b0;
    tick();
    tick();
    check_val("rst_ready", 32'(bus4.req_ready_o), 32'd1);
    check_val("rst_valid", 32'(bus4.rsp_valid_o), 32'd0);
    check_val("rst_result", bus4.result_o, 32'h0);
    rst = 1'b0;
    tick();

    run_op("dec53", 1'b1, 32'h5300_0000, 32'hDEAD_BEEF, 32'h0000_0053);
    run_op("enc1", 1'b0, 32'hFFFF_FF53, 32'h0001_0000, 32'h4801_0000);
    run_op("dec1", 1'b1, 32'h4801_0000, 32'h0, 32'h0000_0053);
    run_op("enc2", 1'b0, 32'h0000_0053, 32'h7702_0100, 32'h9F02_0100);

    // Decode with inputs scrambled during CALC, then backpressure in DONE.
    send_req(1'b1, 32'h9F02_0100, 32'h0);
    bus4.data_i = 32'hFFFF_FFFF;
    bus4.mode_i = 1'b0;
    bus4.rnd_i  = 32'h1234_5678;
    wait_rsp(cyc);
    check_val("bp_lat", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_valid", 32'(bus4.rsp_valid_o), 32'd1);
      check_val("bp_res", bus4.result_o, 32'h0000_0053);
    end
    accept("bp");

    // Clear in the 2nd CALC cycle, with a competing request that must be dropped.
    send_req(1'b0, 32'h0000_00AA, 32'h1122_3344);
    tick();
    clr = 1'b1;
    bus4.req_valid_i = 1'b1;
    bus4.mode_i = 1'b1;
    bus4.data_i = 32'h5300_0000;
    tick();
    clr = 1'b0;
    bus4.req_valid_i = 1'b0;
    check_val("clr_ready", 32'(bus4.req_ready_o), 32'd1);
    check_val("clr_valid", 32'(bus4.rsp_valid_o), 32'd0);
    check_val("clr_result", bus4.result_o, 32'h0);
    tick();
    check_val("clr_noreq", 32'(bus4.req_ready_o), 32'd1);
    run_op("enc0", 1'b0, 32'h0000_0053, 32'h0, 32'h5300_0000);

    // Asynchronous reset mid-CALC.
    send_req(1'b1, 32'h9F02_0100, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_ready", 32'(bus4.req_ready_o), 32'd1);
    check_val("arst_valid", 32'(bus4.rsp_valid_o), 32'd0);
    check_val("arst_result", bus4.result_o, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    run_op("post_rst", 1'b1, 32'h9F02_0100, 32'h0, 32'h0000_0053);

    // N=2 instance: 0x53 ^ gfmul(27, 0x1B) = 0x53 ^ 0x5E = 0x0D, one CALC cycle.
    bus2.mode_i      = 1'b1;
    bus2.data_i      = 16'h531B;
    bus2.req_valid_i = 1'b1;
    tick();
    bus2.req_valid_i = 1'b0;
    cyc = 0;
    while (!bus2.rsp_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    check_val("n2_lat", 32'(cyc), 32'd1);
    check_val("n2_res", 32'(bus2.result_o), 32'h0000_000D);
    bus2.rsp_ready_i = 1'b1;
    tick();
    bus2.rsp_ready_i = 1'b0;
    check_val("n2_scrub", 32'(bus2.result_o), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ipm_codec.md
Name: ipm_codec

Overview:
- Companion block to the IPM GF(256) multiplier. It converts between a plain byte and its N-share inner-product-masked form, in both directions.
- Encode: splits a secret byte x into shares S[0..N-1] such that x = XOR over i of L[i]·S[i].
- Decode: recombines shares into x.
- Sits at the boundary of the masked datapath: it feeds shares into the multiplier and unmasks the multiplier's results. It is iterative and uses a single gfmul instance.

Parameters:
- N, 4, number of shares; legal range 2..4 (elaboration-time assertion).
- WIDTH, N*8, localparam, share vector width.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous abort; returns the block to IDLE.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  block can accept a request.
- mode_i  input  1  0 = encode, 1 = decode; sampled at request handshake.
- data_i  input  WIDTH  encode: secret in [7:0], upper bits ignored. Decode: share vector.
- rnd_i  input  WIDTH  encode randomness; byte i supplies S[i] for i>=1; byte slot 0 is ignored. Ignored in decode.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  encode: share vector. Decode: x in [7:0], upper bits 0.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, result_o=0. FSM=IDLE, k=1, accumulator=0.
- Byte/share i occupies bits [WIDTH-1-8i -: 8]; share 0 sits in the MSB byte.
- Constants, fixed: L = {1, 27, 250, 188}. Only L[0..N-1] are used.
- GF(256) arithmetic uses polynomial 0x11B, identical to gfmul. Addition is XOR.
- FSM IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch mode, data and rnd.
  - Accumulator init: encode → x; decode → S[0] (because L[0]=1).
  - Set k=1 and go to CALC.
- FSM CALC (exactly N-1 cycles):
  - Each cycle: acc <= acc ^ gfmul(L[k], B[k]), where B = latched rnd for encode and latched data for decode.
  - k increments each cycle.
  - When k==N-1, go to DONE. Register the result that edge.
- Encode result: S[0]=acc, S[i]=rnd byte i for i>=1.
- Decode result: {0..., acc}.
- FSM DONE:
  - rsp_valid_o=1, and result_o is held stable.
  - On rsp_ready_i, go to IDLE.
  - On return to IDLE, clear result_o and the accumulator to 0, so no unmasked value lingers.
- Latency: rsp_valid_o rises N-1 cycles after the request-handshake edge (3 for N=4).
- Throughput: one request per N+1 cycles minimum.
- req_ready_o is 0 outside IDLE. A request and a response never handshake in the same cycle.
- rsp_ready_i asserted early (before DONE) has no effect. rsp_valid_o, once high, stays high until accepted.
- Inputs data_i, rnd_i and mode_i are don't-care after the handshake; changing them mid-operation does not affect the result.
- clear_i:
  - Takes priority over every other event in any state.
  - Next cycle: IDLE, rsp_valid_o=0, result_o=0.
  - A request presented in the same cycle as clear_i is not accepted.
- Asynchronous reset mid-operation: immediate return to reset values; the pending result is discarded.
- The gfmul operand mux selects by k only. There is no combinational path from req_* or rsp_* inputs to result_o.

Test Plan:
- Decode, N=4, data=0x53000000 → after 3 CALC cycles rsp_valid_o=1, result_o=0x00000053; req_ready_o=0 during CALC/DONE.
- Encode 0x53, rnd=0x00010000 → result_o=0x48010000 (0x53^0x1B). Feeding it back as a decode → 0x00000053.
- Encode 0x53, rnd=0x00020100 → S0 = 0x53 ^ 0x36 ^ 0xFA = 0x9F → result_o=0x9F020100. Decode of that → 0x53.
- Backpressure: rsp_ready_i held 0 for 5 cycles in DONE → result_o and rsp_valid_o stable. Then accept → next cycle req_ready_o=1 and result_o=0. Also check that changing data_i during CALC does not alter the result.
- clear_i pulsed in the 2nd CALC cycle → IDLE next cycle, no rsp_valid_o. The following encode of 0x53 with rnd=0 → 0x53000000.
- reset_i asserted asynchronously mid-CALC → outputs immediately at reset values. After release, a fresh decode gives the correct result; an N=2 build decoding 0x531B returns 0x53 ^ gfmul(27,0x1B).
